// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl
// Sequencer that feeds a parallel word, LSB first, into a downstream serial
// shift register (which shifts high->low with serial_in entering the MSB).
// A word is accepted over valid/ready, shifted in over exactly WIDTH cycles,
// held for HOLD_CYCLES cycles and then announced with a one-cycle load_done.
// An abort during shifting or holding returns to IDLE with a one-cycle
// aborted pulse. Every output is a decode of registered state.
module shift_load_ctrl #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       abort,
    output logic                       shift_control,
    output logic                       serial_in,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       load_done,
    output logic                       aborted
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [HCW-1:0] HOLD_ZERO = HCW'(0);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);
    // With no hold phase the HOLD state is never entered, so this value is unused.
    localparam logic [HCW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : HCW'(0);
    localparam bit             HOLD_EN   = (HOLD_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    // The buffer shifts right alongside the downstream register, so bit 0
    // is always the next bit to send.
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             aborted_q, aborted_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= {WIDTH{1'b0}};
            bit_cnt_q  <= CNT_ZERO;
            hold_cnt_q <= HOLD_ZERO;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            aborted_q  <= aborted_d;
        end
    end

    // Next-state and datapath update: accept, shift, hold, finish or abort.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        aborted_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort has no meaning here; only a valid word moves us on.
                if (in_valid) begin
                    state_d    = ST_SHIFT;
                    buf_d      = in_data;
                    bit_cnt_d  = CNT_ZERO;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    aborted_d  = 1'b1;
                    bit_cnt_d  = CNT_ZERO;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    buf_d      = {1'b0, buf_q[WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                    hold_cnt_d = HOLD_ZERO;
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d = HOLD_EN ? ST_HOLD : ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    aborted_d  = 1'b1;
                    bit_cnt_d  = CNT_ZERO;
                    hold_cnt_d = HOLD_ZERO;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_DONE;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_DONE: begin
                // abort is too late here; the load has already completed.
                state_d    = ST_IDLE;
                bit_cnt_d  = CNT_ZERO;
                hold_cnt_d = HOLD_ZERO;
            end
            default: begin
                state_d    = ST_IDLE;
                buf_d      = {WIDTH{1'b0}};
                bit_cnt_d  = CNT_ZERO;
                hold_cnt_d = HOLD_ZERO;
            end
        endcase
    end

    // Output decode of the registered state.
    always_comb begin
        in_ready      = 1'b0;
        shift_control = 1'b0;
        serial_in     = 1'b0;
        busy          = 1'b0;
        load_done     = 1'b0;
        bit_cnt       = bit_cnt_q;
        aborted       = aborted_q;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                shift_control = 1'b1;
                serial_in     = buf_q[0];
                busy          = 1'b1;
            end
            ST_HOLD: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                load_done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Testbench for shift_load_ctrl. Two instances share the stimulus: lane 0
// uses HOLD_CYCLES=2, lane 1 uses HOLD_CYCLES=0. A timeline model (cycles
// elapsed since the word was accepted) predicts every output each cycle, and
// a model of the downstream shift register checks what actually got loaded.
module tb_shift_load_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid;
    logic           abort;
    logic [W-1:0]   in_data;
    logic [1:0]     in_ready, shift_control, serial_in, busy, load_done, aborted;
    logic [CW-1:0]  bit_cnt [2];

    shift_load_ctrl #(.WIDTH(W), .HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .abort(abort), .shift_control(shift_control[0]),
        .serial_in(serial_in[0]), .busy(busy[0]), .bit_cnt(bit_cnt[0]),
        .load_done(load_done[0]), .aborted(aborted[0])
    );

    shift_load_ctrl #(.WIDTH(W), .HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .abort(abort), .shift_control(shift_control[1]),
        .serial_in(serial_in[1]), .busy(busy[1]), .bit_cnt(bit_cnt[1]),
        .load_done(load_done[1]), .aborted(aborted[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Model: per lane, whether a load is in progress, which cycle of it we
    // are in (1 = first shift cycle), the word, and the pending aborted pulse.
    bit         m_act [2];
    int         m_t   [2];
    bit [W-1:0] m_word[2];
    bit         m_ab  [2];

    // Downstream register as driven by the DUT, and as the model expects it.
    bit [W-1:0] sr_dut[2];
    bit [W-1:0] sr_exp[2];

    // Bookkeeping for directed checks.
    bit [W-1:0] ld_val[2][0:1023];
    int         ld_n  [2];
    int         ld_cyc[2];
    int         shcnt [2];
    int         ab_n  [2];

    function automatic int hold_of(int lane);
        return (lane == 0) ? 2 : 0;
    endfunction

    task automatic chk(string name, int lane, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d cyc%0d: got 0x%0h, expected 0x%0h", name, lane, cyc, act, exp);
        end
    endtask

    // Model advance on each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] <= 1'b0;
                m_t[i]   <= 0;
                m_ab[i]  <= 1'b0;
            end else if (!m_act[i]) begin
                m_ab[i] <= 1'b0;
                if (in_valid) begin
                    m_act[i]  <= 1'b1;
                    m_word[i] <= in_data;
                    m_t[i]    <= 1;
                end
            end else if (abort && (m_t[i] <= W + hold_of(i))) begin
                m_act[i] <= 1'b0;
                m_ab[i]  <= 1'b1;
            end else if (m_t[i] == W + hold_of(i) + 1) begin
                m_act[i] <= 1'b0;
                m_ab[i]  <= 1'b0;
            end else begin
                m_t[i]  <= m_t[i] + 1;
                m_ab[i] <= 1'b0;
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                bit          e_sh, e_ser, e_ld;
                logic [CW-1:0] e_bc;
                logic [8:0]  e_vec, a_vec;
                e_sh  = m_act[i] && (m_t[i] <= W);
                e_ser = e_sh ? m_word[i][m_t[i]-1] : 1'b0;
                e_ld  = m_act[i] && (m_t[i] == W + hold_of(i) + 1);
                e_bc  = !m_act[i] ? CW'(0) : (e_sh ? CW'(m_t[i] - 1) : CW'(W));
                e_vec = {!m_act[i], e_sh, e_ser, m_act[i], e_bc, e_ld, m_ab[i]};
                a_vec = {in_ready[i], shift_control[i], serial_in[i], busy[i],
                         bit_cnt[i], load_done[i], aborted[i]};
                chk("outputs{rdy,sh,ser,busy,cnt,done,ab}", i, 32'(a_vec), 32'(e_vec));
                chk("shift_reg", i, 32'(sr_dut[i]), 32'(sr_exp[i]));
                if (shift_control[i] === 1'b1) begin
                    sr_dut[i] <= {serial_in[i], sr_dut[i][W-1:1]};
                    shcnt[i]  <= shcnt[i] + 1;
                end
                if (e_sh) sr_exp[i] <= {e_ser, sr_exp[i][W-1:1]};
                if (load_done[i] === 1'b1) begin
                    if (ld_n[i] < 1024) ld_val[i][ld_n[i]] <= sr_dut[i];
                    ld_n[i]   <= ld_n[i] + 1;
                    ld_cyc[i] <= cyc;
                end
                if (aborted[i] === 1'b1) ab_n[i] <= ab_n[i] + 1;
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready0(bit want, int budget, string name);
        int k = 0;
        while (in_ready[0] !== want && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 0, 32'(in_ready[0]), 32'(want));
    endtask

    int acc;
    int n0, n1, s0, s1, a0, a1;

    task automatic snap();
        n0 = ld_n[0]; n1 = ld_n[1];
        s0 = shcnt[0]; s1 = shcnt[1];
        a0 = ab_n[0]; a1 = ab_n[1];
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; in_data = 4'h0;
        step(3);
        rst_n = 1'b1;
        chk("rst_in_ready", 0, 32'(in_ready), 32'(2'b11));
        chk("rst_busy", 0, 32'(busy), 32'(2'b00));

        // Word 4'b1011: serial 1,1,0,1; done at cycle k+7 (hold 2) / k+5 (hold 0).
        snap();
        in_valid = 1'b1; in_data = 4'b1011;
        step(1);
        acc = cyc;
        in_valid = 1'b0; in_data = 4'b0000;
        chk("t2_first_shift", 0, 32'(shift_control), 32'(2'b11));
        chk("t2_first_serial", 0, 32'(serial_in), 32'(2'b11));
        step(10);
        chk("t2_done_cycle_h2", 0, 32'(ld_cyc[0]), 32'(acc + 6));
        chk("t2_done_cycle_h0", 1, 32'(ld_cyc[1]), 32'(acc + 4));
        chk("t2_reg_h2", 0, 32'(ld_val[0][n0]), 32'(4'b1011));
        chk("t2_reg_h0", 1, 32'(ld_val[1][n1]), 32'(4'b1011));
        chk("t2_done_count", 0, 32'(ld_n[0] - n0), 32'd1);
        chk("t2_shift_count", 0, 32'(shcnt[0] - s0), 32'd4);

        // Back-to-back words with in_valid held high.
        snap();
        in_valid = 1'b1; in_data = 4'hA;
        wait_ready0(1'b0, 4, "t3_accept_first");
        in_data = 4'h5;
        wait_ready0(1'b1, 20, "t3_back_to_idle");
        wait_ready0(1'b0, 4, "t3_accept_second");
        in_valid = 1'b0;
        step(12);
        chk("t3_first_reg", 0, 32'(ld_val[0][n0]), 32'(4'hA));
        chk("t3_second_reg", 0, 32'(ld_val[0][n0+1]), 32'(4'h5));
        chk("t3_second_reg_h0", 1, 32'(ld_val[1][n1+1]), 32'(4'h5));
        chk("t3_done_count", 0, 32'(ld_n[0] - n0), 32'd2);
        chk("t3_shift_count", 0, 32'(shcnt[0] - s0), 32'd8);
        chk("t3_shift_count_h0", 1, 32'(shcnt[1] - s1), 32'd8);

        // Abort after two shift cycles of 4'b0110 on a register holding 4'h5.
        snap();
        in_valid = 1'b1; in_data = 4'b0110;
        step(1);
        in_valid = 1'b0;
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_aborted", 0, 32'(aborted), 32'(2'b11));
        chk("t4_no_shift", 0, 32'(shift_control), 32'(2'b00));
        chk("t4_ready", 0, 32'(in_ready), 32'(2'b11));
        chk("t4_partial_reg", 0, 32'(sr_dut[0]), 32'(4'b1001));
        chk("t4_partial_reg_h0", 1, 32'(sr_dut[1]), 32'(4'b1001));
        step(10);
        chk("t4_abort_count", 0, 32'(ab_n[0] - a0), 32'd1);
        chk("t4_no_done", 0, 32'(ld_n[0] - n0), 32'd0);

        // abort during DONE (lane 0) and during IDLE (lane 1) is ignored.
        snap();
        in_valid = 1'b1; in_data = 4'h3;
        step(1);
        in_valid = 1'b0;
        begin
            int k = 0;
            while (load_done[0] !== 1'b1 && k < 20) begin
                step(1);
                k++;
            end
        end
        chk("t6_reach_done", 0, 32'(load_done[0]), 32'd1);
        abort = 1'b1;
        step(2);
        abort = 1'b0;
        step(3);
        chk("t6_done_once", 0, 32'(ld_n[0] - n0), 32'd1);
        chk("t6_done_once_h0", 1, 32'(ld_n[1] - n1), 32'd1);
        chk("t6_no_abort", 0, 32'(ab_n[0] - a0), 32'd0);
        chk("t6_no_abort_h0", 1, 32'(ab_n[1] - a1), 32'd0);

        // Reset two cycles in the middle of shifting.
        snap();
        in_valid = 1'b1; in_data = 4'hC;
        step(1);
        in_valid = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk("t1_ready", 0, 32'(in_ready), 32'(2'b11));
        chk("t1_no_shift", 0, 32'(shift_control), 32'(2'b00));
        chk("t1_not_busy", 0, 32'(busy), 32'(2'b00));
        chk("t1_cnt", 0, 32'(bit_cnt[0]), 32'd0);
        step(10);
        chk("t1_no_done", 0, 32'(ld_n[0] - n0), 32'd0);
        chk("t1_no_abort", 0, 32'(ab_n[0] - a0), 32'd0);

        // Random traffic checked cycle by cycle against the model.
        for (int r = 0; r < 3000; r++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            abort    = ($urandom_range(0, 19) == 0);
            rst_n    = ($urandom_range(0, 199) != 0);
            step(1);
        end
        rst_n = 1'b1; abort = 1'b0; in_valid = 1'b0;
        step(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
